fir_decim_mac: RTL and testbench



---
 rtl/fir_pkg.sv | 41 ++++
 rtl/fir_sample_ram.sv | 28 ++
 rtl/fir_decim_mac.sv | 180 ++++++++++++++++++
 tb/tb_fir_decim_mac.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FIR definitions: pass FSM states, accumulator sizing, and the
// round/saturate stage also used by the interpolator.
package fir_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_MAC,
    ST_DRAIN,
    ST_OUT
  } firState_e;

  localparam int SAT_W = 128;

  function automatic int accWidth(input int inW, input int coefW, input int taps);
    return inW + coefW + $clog2(taps);
  endfunction

  // Round half up at bit 'shift', then clamp into a signed outW-bit range.
  function automatic logic signed [SAT_W-1:0] roundSat(
    input logic signed [SAT_W-1:0] acc,
    input int                      shift,
    input int                      outW
  );
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] rounded;
    logic signed [SAT_W-1:0] maxV;
    logic signed [SAT_W-1:0] minV;
    one     = {{(SAT_W-1){1'b0}}, 1'b1};
    rounded = (acc + (one <<< (shift - 1))) >>> shift;
    maxV    = (one <<< (outW - 1)) - one;
    minV    = -(one <<< (outW - 1));
    if (rounded > maxV) begin
      rounded = maxV;
    end else if (rounded < minV) begin
      rounded = minV;
    end
    return rounded;
  endfunction

endpackage

// File: rtl/fir_sample_ram.sv
// Circular sample buffer: simple dual-port RAM, one write port and a
// registered read port.
module fir_sample_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 24
) (
  input  logic                     clock,
  input  logic                     wrEn_i,
  input  logic [$clog2(DEPTH)-1:0] wrAddr_i,
  input  logic [WIDTH-1:0]         wrData_i,
  input  logic [$clog2(DEPTH)-1:0] rdAddr_i,
  output logic [WIDTH-1:0]         rdData_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdData_q;

  // No reset here so the array maps onto block RAM.
  always_ff @(posedge clock) begin
    if (wrEn_i) begin
      mem[wrAddr_i] <= wrData_i;
    end
    rdData_q <= mem[rdAddr_i];
  end

  assign rdData_o = rdData_q;

endmodule

// File: rtl/fir_decim_mac.sv
// Decimating FIR MAC engine: buffers input samples, and once every DECIM
// accepted samples runs a TAPS-long MAC pass against the external coefficient ROM.
module fir_decim_mac
  import fir_pkg::*;
#(
  parameter int TAPS     = 1024,
  parameter int DECIM    = 8,
  parameter int IN_W     = 24,
  parameter int COEF_W   = 18,
  parameter int OUT_W    = 24,
  parameter int COEF_LAT = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_data,
  output logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]       coef_q,
  output logic                    out_valid,
  output logic [OUT_W-1:0]        out_data,
  output logic                    busy
);

  localparam int AW     = $clog2(TAPS);
  localparam int PW     = $clog2(DECIM + 1);
  localparam int DW     = $clog2(COEF_LAT + 2);
  localparam int PROD_W = IN_W + COEF_W;
  localparam int ACC_W  = accWidth(IN_W, COEF_W, TAPS);

  firState_e                state_q, state_d;
  logic [AW-1:0]            cnt_q, cnt_d;
  logic [AW-1:0]            wptr_q, wptr_d;
  logic [PW-1:0]            phase_q, phase_d;
  logic [DW-1:0]            drain_q, drain_d;
  logic [COEF_LAT:0]        vld_q;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [OUT_W-1:0]         outData_q, outData_d;
  logic                     busy_q;

  logic                     ramWrEn;
  logic [AW-1:0]            ramWrAddr;
  logic [IN_W-1:0]          ramWrData;
  logic [AW-1:0]            ramRdAddr;
  logic [IN_W-1:0]          ramRdData;
  logic                     issue;
  logic signed [IN_W-1:0]   sampleAligned;
  logic signed [SAT_W-1:0]  accRounded;
  logic                     unusedRoundHi;

  fir_sample_ram #(
    .DEPTH(TAPS),
    .WIDTH(IN_W)
  ) uSampleRam (
    .clock   (clock),
    .wrEn_i  (ramWrEn),
    .wrAddr_i(ramWrAddr),
    .wrData_i(ramWrData),
    .rdAddr_i(ramRdAddr),
    .rdData_o(ramRdData)
  );

  // Newest sample pairs with coefficient 0; wrap is plain mod-TAPS arithmetic.
  assign ramRdAddr = wptr_q - AW'(1) - cnt_q;

  if (COEF_LAT > 1) begin : gSampleDelay
    logic [IN_W-1:0] dly_q [COEF_LAT-1];
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < COEF_LAT - 1; i++) dly_q[i] <= '0;
      end else begin
        dly_q[0] <= ramRdData;
        for (int i = 1; i < COEF_LAT - 1; i++) dly_q[i] <= dly_q[i-1];
      end
    end
    assign sampleAligned = $signed(dly_q[COEF_LAT-2]);
  end else begin : gSampleDirect
    assign sampleAligned = $signed(ramRdData);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wptr_d    = wptr_q;
    phase_d   = phase_q;
    drain_d   = drain_q;
    outData_d = outData_q;
    ramWrEn   = 1'b0;
    ramWrAddr = cnt_q;
    ramWrData = '0;
    issue     = 1'b0;
    in_ready  = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        ramWrEn = 1'b1;
        cnt_d   = cnt_q + AW'(1);
        if (cnt_q == AW'(TAPS - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        in_ready  = 1'b1;
        ramWrAddr = wptr_q;
        ramWrData = in_data;
        if (in_valid) begin
          ramWrEn = 1'b1;
          wptr_d  = wptr_q + AW'(1);
          if (phase_q == PW'(DECIM - 1)) begin
            phase_d = '0;
            state_d = ST_MAC;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
      end
      ST_MAC: begin
        issue = 1'b1;
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(TAPS - 1)) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + DW'(1);
        // The last product lands in acc_d on this cycle, so capture from it.
        if (drain_q == DW'(COEF_LAT)) begin
          state_d   = ST_OUT;
          outData_d = accRounded[OUT_W-1:0];
        end
      end
      ST_OUT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    if (vld_q[COEF_LAT]) acc_d = acc_q + ACC_W'(prod_q);
    if (state_q == ST_OUT) acc_d = '0;
  end

  assign accRounded    = roundSat(SAT_W'(acc_d), COEF_W - 1, OUT_W);
  assign unusedRoundHi = ^accRounded[SAT_W-1:OUT_W];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= '0;
      wptr_q    <= '0;
      phase_q   <= '0;
      drain_q   <= '0;
      vld_q     <= '0;
      prod_q    <= '0;
      acc_q     <= '0;
      outData_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      phase_q   <= phase_d;
      drain_q   <= drain_d;
      vld_q     <= {vld_q[COEF_LAT-1:0], issue};
      prod_q    <= PROD_W'(sampleAligned) * PROD_W'($signed(coef_q));
      acc_q     <= acc_d;
      outData_q <= outData_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign coef_addr = cnt_q;
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = outData_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fir_decim_mac.sv
// Self-checking bench for fir_decim_mac: random and directed stimulus scored
// against a history-based convolution model of the decimating filter.
module tb_fir_decim_mac;

  localparam int TAPS     = 1024;
  localparam int DECIM    = 8;
  localparam int IN_W     = 24;
  localparam int COEF_W   = 18;
  localparam int OUT_W    = 24;
  localparam int COEF_LAT = 1;
  localparam int AW       = $clog2(TAPS);

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IN_W-1:0]   in_data = '0;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_q;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;
  logic              busy;

  int     coefRom [TAPS];
  int     hist[$];
  int     stim[$];
  int     acceptQ[$];
  int     passAccept[$];
  longint expQ[$];
  longint obsData[$];
  int     obsCycle[$];
  longint lastOut[$];
  int     cycleCnt = 0;
  int     checkCount = 0;
  int     passCount = 0;

  fir_decim_mac #(
    .TAPS(TAPS), .DECIM(DECIM), .IN_W(IN_W),
    .COEF_W(COEF_W), .OUT_W(OUT_W), .COEF_LAT(COEF_LAT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .coef_addr(coef_addr),
    .coef_q   (coef_q),
    .out_valid(out_valid),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  // External coefficient ROM with one clock of read latency.
  always @(posedge clock) coef_q <= COEF_W'(coefRom[coef_addr]);

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  // Record every output strobe and the cycle it was seen in.
  always @(negedge clock) begin
    if (out_valid) begin
      obsData.push_back(longint'($signed(out_data)));
      obsCycle.push_back(cycleCnt);
    end
  end

  initial begin
    #(900000);
    $display("[TB] FAIL watchdog: simulation ran past its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    checkCount++;
    if (got !== exp) begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      passCount++;
    end
  endtask

  // Direct-form convolution over every sample accepted since reset;
  // samples older than reset read as zero because CLEAR wiped the buffer.
  function automatic longint modelOutput();
    longint acc;
    longint rounded;
    longint maxV;
    longint minV;
    int     n;
    n    = hist.size();
    acc  = 0;
    maxV = (longint'(1) <<< (OUT_W - 1)) - 1;
    minV = -(longint'(1) <<< (OUT_W - 1));
    for (int k = 0; k < TAPS && k < n; k++) begin
      acc += longint'(coefRom[k]) * longint'(hist[n-1-k]);
    end
    rounded = (acc + (longint'(1) <<< (COEF_W - 2))) >>> (COEF_W - 1);
    if (rounded > maxV) rounded = maxV;
    if (rounded < minV) rounded = minV;
    return rounded;
  endfunction

  function automatic int randSample();
    return int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W - 1));
  endfunction

  function automatic int randCoef();
    return int'($urandom_range(0, (1 << COEF_W) - 1)) - (1 << (COEF_W - 1));
  endfunction

  // Offer one sample and hold it until the block takes it; leaves in_valid high.
  task automatic applyStimulus(input int x);
    int waitCycles;
    in_valid   = 1'b1;
    in_data    = IN_W'(x);
    waitCycles = 0;
    while (!in_ready && waitCycles < 3 * TAPS) begin
      @(negedge clock);
      waitCycles++;
    end
    if (!in_ready) begin
      checkOutput("acceptTimeout", 0, 1);
    end else begin
      acceptQ.push_back(cycleCnt);
      hist.push_back(x);
    end
    @(negedge clock);
  endtask

  task automatic doReset();
    int n;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    @(negedge clock);
    checkOutput("rstInReady", in_ready, 0);
    checkOutput("rstOutValid", out_valid, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstOutData", longint'($signed(out_data)), 0);
    checkOutput("rstCoefAddr", coef_addr, 0);
    @(negedge clock);
    reset = 1'b0;
    hist.delete();
    @(negedge clock);
    checkOutput("busyAfterRst", busy, 1);
    n = 1;
    while (!in_ready && n < TAPS + 20) begin
      @(negedge clock);
      n++;
    end
    checkOutput("clearLength", n, TAPS);
    checkOutput("noOutDuringClear", obsData.size(), 0);
    checkOutput("busyInIdle", busy, 0);
    checkOutput("outDataAfterRst", longint'($signed(out_data)), 0);
  endtask

  // Drive stim[], score every decimated output against the model,
  // its latency, and (with no idle gaps) the acceptance spacing.
  task automatic runStim(input int gapMax);
    int w;
    longint got;
    acceptQ.delete();
    passAccept.delete();
    expQ.delete();
    foreach (stim[i]) begin
      if (gapMax > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, gapMax)) @(negedge clock);
      end
      applyStimulus(stim[i]);
      if (hist.size() % DECIM == 0) begin
        expQ.push_back(modelOutput());
        passAccept.push_back(acceptQ[acceptQ.size()-1]);
      end
    end
    in_valid = 1'b0;
    w = 0;
    while (obsData.size() < expQ.size() && w < TAPS + 80) begin
      @(negedge clock);
      w++;
    end
    repeat (4) @(negedge clock);
    checkOutput("outCount", obsData.size(), expQ.size());
    foreach (expQ[m]) begin
      got = (m < obsData.size()) ? obsData[m] : 64'sd12345678901;
      checkOutput($sformatf("outData[%0d]", m), got, expQ[m]);
      if (m < obsCycle.size()) begin
        checkOutput($sformatf("latency[%0d]", m), obsCycle[m] - passAccept[m],
                    TAPS + COEF_LAT + 2);
      end
    end
    if (expQ.size() > 0) begin
      checkOutput("outHeld", longint'($signed(out_data)), expQ[expQ.size()-1]);
    end
    if (gapMax == 0) begin
      for (int i = 1; i < acceptQ.size(); i++) begin
        checkOutput($sformatf("acceptGap[%0d]", i), acceptQ[i] - acceptQ[i-1],
                    (i % DECIM == 0) ? TAPS + COEF_LAT + 3 : 1);
      end
    end
    lastOut = obsData;
    obsData.delete();
    obsCycle.delete();
    stim.delete();
  endtask

  initial begin
    int roundVals [4];
    int roundExp  [4];
    int w;
    roundVals = '{65536, -65536, -65537, 65535};
    roundExp  = '{1, 0, -1, 0};
    for (int k = 0; k < TAPS; k++) coefRom[k] = k - 512;
    @(negedge clock);
    doReset();

    // Impulse on the last sample of the first pass, continuous valid.
    for (int i = 0; i < 12 * DECIM; i++) stim.push_back((i == DECIM - 1) ? 131072 : 0);
    runStim(0);
    for (int m = 0; m < 12; m++) begin
      if (m < lastOut.size()) checkOutput($sformatf("impulse[%0d]", m), lastOut[m], -512 + 8 * m);
    end

    // Rounding at the half-LSB boundary through a single unit tap.
    for (int k = 0; k < TAPS; k++) coefRom[k] = 0;
    coefRom[0] = 1;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < DECIM - 1; i++) stim.push_back(0);
      stim.push_back(roundVals[p]);
    end
    runStim(0);
    for (int p = 0; p < 4; p++) begin
      if (p < lastOut.size()) checkOutput($sformatf("round[%0d]", p), lastOut[p], roundExp[p]);
    end

    // Random coefficients and samples with random idle gaps.
    for (int k = 0; k < TAPS; k++) coefRom[k] = randCoef();
    for (int i = 0; i < 6 * DECIM; i++) stim.push_back(randSample());
    runStim(3);

    // Abort a pass at MAC k=500, then compare a fresh run against a fresh model.
    for (int i = 0; i < DECIM; i++) applyStimulus(randSample());
    in_valid = 1'b0;
    w = 0;
    while (coef_addr != AW'(500) && w < 2 * TAPS) begin
      @(negedge clock);
      w++;
    end
    checkOutput("abortPoint", coef_addr, 500);
    doReset();
    for (int i = 0; i < 2 * DECIM; i++) stim.push_back(randSample());
    runStim(0);

    // Positive and negative saturation.
    for (int k = 0; k < TAPS; k++) coefRom[k] = 131071;
    doReset();
    for (int i = 0; i < 2 * DECIM; i++) stim.push_back(4194304);
    runStim(0);
    for (int m = 0; m < 2; m++) begin
      if (m < lastOut.size()) checkOutput($sformatf("satPos[%0d]", m), lastOut[m], 8388607);
    end
    doReset();
    for (int i = 0; i < 2 * DECIM; i++) stim.push_back(-4194304);
    runStim(0);
    for (int m = 0; m < 2; m++) begin
      if (m < lastOut.size()) checkOutput($sformatf("satNeg[%0d]", m), lastOut[m], -8388608);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
